prefetch_mem_slice: RTL and testbench

//  Registered AXI read-path slice between prefetcherTop master side (m_ar/m_r) and DRAM (axi_ram).

---
 rtl/prefetch_pkg.sv | 30 +++
 rtl/axi_skid_buf.sv | 66 ++++++
 rtl/prefetch_mem_slice.sv | 130 +++++++++++++
 tb/tb_prefetch_mem_slice.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prefetch_pkg.sv
// Shared types and constants for the prefetcher-to-DRAM read slice.
// The struct typedefs describe the default build; the top derives its own from its parameters.
package prefetch_pkg;

   localparam int unsigned ADDR_BITS_DEF = 16;
   localparam int unsigned LEN_W_DEF     = 8;
   localparam int unsigned TID_W_DEF     = 8;
   localparam int unsigned LOG_BDB_DEF   = 0;
   localparam int unsigned DATA_W        = 8 << LOG_BDB_DEF;

   localparam int unsigned ERR_TIMEOUT   = 0;
   localparam int unsigned ERR_UNDERFLOW = 1;

   typedef struct packed {
      logic [ADDR_BITS_DEF-1:0] addr;
      logic [LEN_W_DEF-1:0]     len;
      logic [TID_W_DEF-1:0]     id;
   } ar_payload_t;

   typedef struct packed {
      logic                 last;
      logic [DATA_W-1:0]    data;
      logic [TID_W_DEF-1:0] id;
   } r_payload_t;

   function automatic int unsigned data_width(input int unsigned log_bytes);
      return 8 << log_bytes;
   endfunction

endpackage

// File: rtl/axi_skid_buf.sv
// Two-entry valid/ready register slice: registered valid and ready, one-cycle latency,
// full throughput while the consumer keeps ready high.
module axi_skid_buf #(
   parameter type T = logic [7:0]
) (
   input  logic clk,
   input  logic resetN,
   input  logic in_valid_i,
   output logic in_ready_o,
   input  T     in_data_i,
   output logic out_valid_o,
   input  logic out_ready_i,
   output T     out_data_o
);

   T     main_q, main_d;
   T     skid_q, skid_d;
   logic main_vld_q, main_vld_d;
   logic skid_vld_q, skid_vld_d;
   logic rdy_q;
   logic in_fire;

   // Input is only accepted while the skid entry is free, so a stalled main entry
   // can always park exactly one more beat.
   always_comb begin
      in_fire    = in_valid_i & rdy_q;
      main_d     = main_q;
      main_vld_d = main_vld_q;
      skid_d     = skid_q;
      skid_vld_d = skid_vld_q;
      if (!main_vld_q || out_ready_i) begin
         if (skid_vld_q) begin
            main_d     = skid_q;
            main_vld_d = 1'b1;
            skid_vld_d = 1'b0;
         end else begin
            main_vld_d = in_fire;
            if (in_fire) main_d = in_data_i;
         end
      end else if (in_fire) begin
         skid_d     = in_data_i;
         skid_vld_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         main_q     <= '0;
         skid_q     <= '0;
         main_vld_q <= 1'b0;
         skid_vld_q <= 1'b0;
         rdy_q      <= 1'b0;
      end else begin
         main_q     <= main_d;
         skid_q     <= skid_d;
         main_vld_q <= main_vld_d;
         skid_vld_q <= skid_vld_d;
         rdy_q      <= !skid_vld_d;
      end
   end

   assign in_ready_o  = rdy_q;
   assign out_valid_o = main_vld_q;
   assign out_data_o  = main_q;

endmodule

// File: rtl/prefetch_mem_slice.sv
// Registered AXI read-path slice between the prefetcher and DRAM with an outstanding-burst
// cap, a response watchdog and sticky error flags.
module prefetch_mem_slice
   import prefetch_pkg::*;
#(
   parameter int unsigned ADDR_BITS            = 16,
   parameter int unsigned BURST_LEN_WIDTH      = 8,
   parameter int unsigned TID_WIDTH            = 8,
   parameter int unsigned LOG_BLOCK_DATA_BYTES = 0,
   parameter int unsigned LOG_OUTSTANDING      = 3,
   parameter int unsigned WATCHDOG_SIZE        = 10
) (
   input  logic                                         clk,
   input  logic                                         resetN,
   input  logic                                         en,
   input  logic                                         s_ar_valid,
   output logic                                         s_ar_ready,
   input  logic [ADDR_BITS-1:0]                         s_ar_addr,
   input  logic [BURST_LEN_WIDTH-1:0]                   s_ar_len,
   input  logic [TID_WIDTH-1:0]                         s_ar_id,
   output logic                                         m_ar_valid,
   input  logic                                         m_ar_ready,
   output logic [ADDR_BITS-1:0]                         m_ar_addr,
   output logic [BURST_LEN_WIDTH-1:0]                   m_ar_len,
   output logic [TID_WIDTH-1:0]                         m_ar_id,
   input  logic                                         m_r_valid,
   output logic                                         m_r_ready,
   input  logic                                         m_r_last,
   input  logic [data_width(LOG_BLOCK_DATA_BYTES)-1:0]  m_r_data,
   input  logic [TID_WIDTH-1:0]                         m_r_id,
   output logic                                         s_r_valid,
   input  logic                                         s_r_ready,
   output logic                                         s_r_last,
   output logic [data_width(LOG_BLOCK_DATA_BYTES)-1:0]  s_r_data,
   output logic [TID_WIDTH-1:0]                         s_r_id,
   input  logic [WATCHDOG_SIZE-1:0]                     watchdogCnt,
   output logic [LOG_OUTSTANDING:0]                     outstanding,
   output logic [2:0]                                   errorCode
);

   localparam int unsigned RDW = data_width(LOG_BLOCK_DATA_BYTES);
   localparam logic [LOG_OUTSTANDING:0] MAX_OUT = {1'b1, {LOG_OUTSTANDING{1'b0}}};

   typedef struct packed {
      logic [ADDR_BITS-1:0]       addr;
      logic [BURST_LEN_WIDTH-1:0] len;
      logic [TID_WIDTH-1:0]       id;
   } ar_t;

   typedef struct packed {
      logic                 last;
      logic [RDW-1:0]       data;
      logic [TID_WIDTH-1:0] id;
   } r_t;

   ar_t  ar_out;
   r_t   r_out;
   logic ar_buf_rdy, cap_ok, ar_in_fire, r_in_fire, r_last_fire;

   logic [LOG_OUTSTANDING:0] out_q, out_d;
   logic [WATCHDOG_SIZE-1:0] wd_q, wd_d;
   logic [2:0]               err_q, err_d;

   assign cap_ok      = out_q < MAX_OUT;
   assign s_ar_ready  = ar_buf_rdy & en & cap_ok;
   assign ar_in_fire  = s_ar_valid & s_ar_ready;
   assign r_in_fire   = m_r_valid & m_r_ready;
   assign r_last_fire = s_r_valid & s_r_ready & s_r_last;

   axi_skid_buf #(.T(ar_t)) u_ar_buf (
      .clk        (clk),
      .resetN     (resetN),
      .in_valid_i (s_ar_valid & en & cap_ok),
      .in_ready_o (ar_buf_rdy),
      .in_data_i  ('{addr: s_ar_addr, len: s_ar_len, id: s_ar_id}),
      .out_valid_o(m_ar_valid),
      .out_ready_i(m_ar_ready),
      .out_data_o (ar_out)
   );

   axi_skid_buf #(.T(r_t)) u_r_buf (
      .clk        (clk),
      .resetN     (resetN),
      .in_valid_i (m_r_valid),
      .in_ready_o (m_r_ready),
      .in_data_i  ('{last: m_r_last, data: m_r_data, id: m_r_id}),
      .out_valid_o(s_r_valid),
      .out_ready_i(s_r_ready),
      .out_data_o (r_out)
   );

   assign m_ar_addr = ar_out.addr;
   assign m_ar_len  = ar_out.len;
   assign m_ar_id   = ar_out.id;
   assign s_r_last  = r_out.last;
   assign s_r_data  = r_out.data;
   assign s_r_id    = r_out.id;

   always_comb begin
      out_d = out_q;
      err_d = err_q;
      wd_d  = wd_q;
      if (ar_in_fire && !r_last_fire) begin
         out_d = out_q + 1'b1;
      end else if (r_last_fire && !ar_in_fire) begin
         if (out_q == '0) err_d[ERR_UNDERFLOW] = 1'b1;
         else             out_d = out_q - 1'b1;
      end
      // Watchdog only runs while DRAM owes data and no R beat is moving.
      if (r_in_fire || out_q == '0) wd_d = '0;
      else if (wd_q != '1)           wd_d = wd_q + 1'b1;
      if (watchdogCnt != '0 && wd_d >= watchdogCnt) err_d[ERR_TIMEOUT] = 1'b1;
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         out_q <= '0;
         wd_q  <= '0;
         err_q <= '0;
      end else begin
         out_q <= out_d;
         wd_q  <= wd_d;
         err_q <= err_d;
      end
   end

   assign outstanding = out_q;
   assign errorCode   = err_q;

endmodule

// File: tb/tb_prefetch_mem_slice.sv
// Bench for prefetch_mem_slice: queue scoreboard plus counter/error model checked every cycle,
// DRAM and prefetcher emulation driven from one process, directed scenarios from another.
module tb_prefetch_mem_slice;

   localparam int MAXO = 8;
   localparam int WS   = 10;

   typedef struct packed {
      logic [15:0] addr;
      logic [7:0]  len;
      logic [7:0]  id;
   } ar_s;

   typedef struct packed {
      logic       last;
      logic [7:0] data;
      logic [7:0] id;
   } r_s;

   logic        clk = 1'b0;
   logic        resetN, en;
   logic        s_ar_valid, s_ar_ready, m_ar_valid, m_ar_ready;
   logic [15:0] s_ar_addr, m_ar_addr;
   logic [7:0]  s_ar_len, m_ar_len, s_ar_id, m_ar_id;
   logic        m_r_valid, m_r_ready, m_r_last, s_r_valid, s_r_ready, s_r_last;
   logic [7:0]  m_r_data, m_r_id, s_r_data, s_r_id;
   logic [9:0]  watchdogCnt;
   logic [3:0]  outstanding;
   logic [2:0]  errorCode;

   always #5 clk = ~clk;

   prefetch_mem_slice #(
      .ADDR_BITS(16), .BURST_LEN_WIDTH(8), .TID_WIDTH(8),
      .LOG_BLOCK_DATA_BYTES(0), .LOG_OUTSTANDING(3), .WATCHDOG_SIZE(WS)
   ) dut (
      .clk(clk), .resetN(resetN), .en(en),
      .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_addr(s_ar_addr),
      .s_ar_len(s_ar_len), .s_ar_id(s_ar_id),
      .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr),
      .m_ar_len(m_ar_len), .m_ar_id(m_ar_id),
      .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_last(m_r_last),
      .m_r_data(m_r_data), .m_r_id(m_r_id),
      .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_last(s_r_last),
      .s_r_data(s_r_data), .s_r_id(s_r_id),
      .watchdogCnt(watchdogCnt), .outstanding(outstanding), .errorCode(errorCode)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      failures++;
      $display("FAIL %s: unexpected event at %0t", name, $time);
   endtask

   // Model state (monitor-owned)
   ar_s    sb_ar[$];
   r_s     sb_r[$];
   int     m_out = 0;
   int     m_wd = 0;
   logic [2:0] m_err = '0;
   longint nr_ar_acc = 0, nr_r_beats = 0;
   bit     f_ar_in = 0, f_ar_out = 0, f_r_in = 0;
   ar_s    f_ar_pl;

   // Stimulus state (main-owned unless noted)
   ar_s tx_q[$];
   int  ar_rand = 0, ardy_mode = 0, r_mode = 0, sr_mode = 0;
   int  r_grant = 0, inj_req = 0;
   // driver-owned
   ar_s dram_q[$];
   int  beat = 0, r_used = 0, inj_served = 0;
   bit  inj_active = 0;

   function automatic bit idle();
      return tx_q.size() == 0 && dram_q.size() == 0 && sb_ar.size() == 0 &&
             sb_r.size() == 0 && m_out == 0 && !inj_active;
   endfunction

   function automatic logic pick(input int mode);
      return (mode == 1) || (mode == 2 && $urandom_range(0, 1) == 1);
   endfunction

   // Monitor: compare against the model, then advance the model by the handshakes of the coming edge.
   always @(negedge clk) begin
      if (!resetN) begin
         sb_ar.delete();
         sb_r.delete();
         m_out = 0; m_wd = 0; m_err = '0;
         f_ar_in = 0; f_ar_out = 0; f_r_in = 0;
         chk("rst_valids_readies", {s_ar_ready, m_ar_valid, m_r_ready, s_r_valid}, 0);
         chk("rst_outstanding", outstanding, 0);
         chk("rst_errorCode", errorCode, 0);
      end else begin
         bit inc, dec;
         chk("outstanding", outstanding, m_out);
         chk("errorCode", errorCode, m_err);
         chk("s_ar_ready_gate", s_ar_ready & !(en && m_out < MAXO), 0);
         f_ar_in  = s_ar_valid && s_ar_ready;
         f_ar_out = m_ar_valid && m_ar_ready;
         f_r_in   = m_r_valid && m_r_ready;
         f_ar_pl  = '{addr: m_ar_addr, len: m_ar_len, id: m_ar_id};
         if (f_ar_out) begin
            if (sb_ar.size() == 0) fail("m_ar_spurious");
            else chk("m_ar_payload", {m_ar_addr, m_ar_len, m_ar_id}, sb_ar.pop_front());
         end
         if (f_ar_in) begin
            sb_ar.push_back('{addr: s_ar_addr, len: s_ar_len, id: s_ar_id});
            nr_ar_acc++;
         end
         if (s_r_valid && s_r_ready) begin
            if (sb_r.size() == 0) fail("s_r_spurious");
            else chk("s_r_payload", {s_r_last, s_r_data, s_r_id}, sb_r.pop_front());
            nr_r_beats++;
         end
         if (f_r_in) sb_r.push_back('{last: m_r_last, data: m_r_data, id: m_r_id});
         inc = f_ar_in;
         dec = s_r_valid && s_r_ready && s_r_last;
         if (f_r_in || m_out == 0) m_wd = 0;
         else if (m_wd < (1 << WS) - 1) m_wd++;
         if (inc && !dec) m_out++;
         else if (dec && !inc) begin
            if (m_out == 0) m_err[1] = 1'b1;
            else m_out--;
         end
         if (watchdogCnt != 0 && m_wd >= int'(watchdogCnt)) m_err[0] = 1'b1;
      end
   end

   // Prefetcher and DRAM emulation
   initial begin
      s_ar_valid = 0; s_ar_addr = 0; s_ar_len = 0; s_ar_id = 0;
      m_ar_ready = 0; m_r_valid = 0; m_r_last = 0; m_r_data = 0; m_r_id = 0; s_r_ready = 0;
      forever begin
         @(posedge clk);
         #1;
         if (!resetN) begin
            dram_q.delete();
            beat = 0;
            inj_active = 0;
            s_ar_valid = 0; m_ar_ready = 0; m_r_valid = 0; s_r_ready = 0;
         end else begin
            if (f_r_in) begin
               if (inj_active) begin
                  inj_active = 0;
                  inj_served++;
               end else if (dram_q.size() > 0) begin
                  r_used++;
                  if (beat == int'(dram_q[0].len)) begin
                     void'(dram_q.pop_front());
                     beat = 0;
                  end else beat++;
               end
            end
            if (f_ar_out) dram_q.push_back(f_ar_pl);
            if (f_ar_in && tx_q.size() > 0) void'(tx_q.pop_front());
            if (tx_q.size() > 0 && (ar_rand == 0 || $urandom_range(0, 1) == 1)) begin
               s_ar_valid = 1;
               {s_ar_addr, s_ar_len, s_ar_id} = tx_q[0];
            end else s_ar_valid = 0;
            m_ar_ready = pick(ardy_mode);
            s_r_ready  = pick(sr_mode);
            if (!inj_active && inj_served != inj_req) inj_active = 1;
            if (inj_active) begin
               m_r_valid = 1; m_r_last = 1; m_r_data = 8'hA5; m_r_id = 8'h77;
            end else if (dram_q.size() > 0 &&
                         (pick(r_mode) || (r_mode == 3 && r_used < r_grant))) begin
               m_r_valid = 1;
               m_r_data  = 8'(beat);
               m_r_id    = dram_q[0].id;
               m_r_last  = (beat == int'(dram_q[0].len));
            end else m_r_valid = 0;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      step();
      resetN = 0;
      tx_q.delete();
      en = 0; ar_rand = 0; ardy_mode = 0; r_mode = 0; sr_mode = 0;
      r_grant = r_used;
      repeat (2) @(negedge clk);
      #1 resetN = 1;
   endtask

   task automatic wait_idle(input string name, input int budget);
      for (int c = 0; c < budget && !idle(); c++) step();
      chk(name, idle(), 1);
   endtask

   initial begin
      longint base;
      int     hs_cyc, max_out, n;
      logic [7:0] got_d[$];
      logic       got_l[$];
      bit         seen;

      resetN = 0; en = 0; watchdogCnt = 0;
      #2;
      chk("init_s_ar_ready", s_ar_ready, 0);
      chk("init_m_r_ready", m_r_ready, 0);
      chk("init_m_ar_valid", m_ar_valid, 0);
      chk("init_s_r_valid", s_r_valid, 0);
      chk("init_outstanding", outstanding, 0);
      chk("init_errorCode", errorCode, 0);
      repeat (2) @(negedge clk);
      #1 resetN = 1;

      // Single burst, everything ready
      step();
      en = 1; ardy_mode = 1; r_mode = 1; sr_mode = 1;
      tx_q.push_back('{addr: 16'h0eef, len: 8'd3, id: 8'd5});
      hs_cyc = -10; max_out = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (i == hs_cyc + 1) begin
            chk("t1_m_ar_valid", m_ar_valid, 1);
            chk("t1_m_ar_addr", m_ar_addr, 16'h0eef);
         end
         if (s_ar_valid && s_ar_ready) hs_cyc = i;
         if (s_r_valid && s_r_ready) begin
            got_d.push_back(s_r_data);
            got_l.push_back(s_r_last);
         end
         if (int'(outstanding) > max_out) max_out = int'(outstanding);
      end
      chk("t1_beats", got_d.size(), 4);
      for (int k = 0; k < got_d.size(); k++) begin
         chk("t1_data", got_d[k], k);
         chk("t1_last", got_l[k], k == 3);
      end
      chk("t1_max_outstanding", max_out, 1);
      chk("t1_final_outstanding", outstanding, 0);

      // Outstanding cap
      do_reset();
      en = 1; ardy_mode = 1; r_mode = 3; sr_mode = 1;
      base = nr_ar_acc;
      for (int i = 0; i < 9; i++) tx_q.push_back('{addr: 16'(i * 16), len: 8'd0, id: 8'(i)});
      repeat (30) step();
      @(negedge clk);
      chk("t2_outstanding_cap", outstanding, 8);
      chk("t2_s_ar_ready_low", s_ar_ready, 0);
      chk("t2_accepted", nr_ar_acc - base, 8);
      step();
      r_grant = r_grant + 1;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (outstanding == 4'd7) begin
            seen = 1;
            chk("t2_slot_freed_ready", s_ar_ready, 1);
         end
      end
      chk("t2_slot_freed_seen", seen, 1);
      @(negedge clk);
      chk("t2_ninth_accepted", nr_ar_acc - base, 9);
      chk("t2_outstanding_refill", outstanding, 8);

      // Randomised traffic
      do_reset();
      watchdogCnt = 10'd20;
      en = 1; ar_rand = 1; ardy_mode = 2; r_mode = 2; sr_mode = 2;
      base = nr_r_beats;
      n = 0;
      while (n < 200) begin
         ar_s a;
         a.addr = 16'($urandom);
         a.len  = 8'($urandom_range(0, 7));
         a.id   = 8'($urandom);
         n += int'(a.len) + 1;
         tx_q.push_back(a);
      end
      for (int c = 0; c < 6000 && !idle(); c++) begin
         step();
         if (c > 3000) en = 1;
         else if ($urandom_range(0, 19) == 0) en = ~en;
      end
      en = 1;
      wait_idle("t3_drain", 2000);
      chk("t3_beats", nr_r_beats - base, n);

      // Watchdog timeout
      do_reset();
      watchdogCnt = 10'd10;
      en = 1; ardy_mode = 1; r_mode = 0; sr_mode = 1;
      tx_q.push_back('{addr: 16'h1234, len: 8'd1, id: 8'd9});
      seen = 0;
      for (int i = 0; i < 30 && !seen; i++) begin
         @(negedge clk);
         seen = (outstanding == 4'd1);
      end
      chk("t4_outstanding_one", seen, 1);
      n = 0;
      for (int i = 0; i < 30 && !errorCode[0]; i++) begin
         @(negedge clk);
         n++;
      end
      chk("t4_timeout_latency", n, 10);
      chk("t4_errorCode", errorCode, 3'b001);
      repeat (20) step();
      @(negedge clk);
      chk("t4_errorCode_sticky", errorCode, 3'b001);
      step();
      r_mode = 1;
      wait_idle("t4_drain_after_timeout", 100);
      @(negedge clk);
      chk("t4_errorCode_after_drain", errorCode, 3'b001);

      // Underflow
      do_reset();
      watchdogCnt = 0;
      en = 1; sr_mode = 1;
      step();
      inj_req = inj_req + 1;
      for (int i = 0; i < 20 && inj_served != inj_req; i++) step();
      chk("t5_injected", inj_served, inj_req);
      repeat (4) step();
      @(negedge clk);
      chk("t5_errorCode", errorCode, 3'b010);
      chk("t5_outstanding", outstanding, 0);

      // Reset mid-burst
      do_reset();
      en = 1; ardy_mode = 1; r_mode = 2; sr_mode = 2;
      tx_q.push_back('{addr: 16'h0100, len: 8'd7, id: 8'd3});
      base = nr_r_beats;
      for (int i = 0; i < 100 && nr_r_beats == base; i++) step();
      chk("t6_burst_started", nr_r_beats > base, 1);
      @(posedge clk);
      #3 resetN = 0;
      #1;
      chk("t6_async_valids_readies", {s_ar_ready, m_ar_valid, m_r_ready, s_r_valid}, 0);
      chk("t6_async_outstanding", outstanding, 0);
      chk("t6_async_errorCode", errorCode, 0);
      tx_q.delete();
      r_grant = r_used;
      repeat (2) @(negedge clk);
      #1 resetN = 1;
      step();
      en = 1; ardy_mode = 1; r_mode = 1; sr_mode = 1;
      base = nr_r_beats;
      tx_q.push_back('{addr: 16'h0200, len: 8'd3, id: 8'd4});
      wait_idle("t6_clean_burst", 100);
      chk("t6_clean_beats", nr_r_beats - base, 4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
